// File: rtl/switch_pkg.sv
// Shared definitions for the switch fabric and its grant generator.
package switch_pkg;

  localparam int N_PORTS = 8;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;

  // Index of an input or output port.
  typedef logic [2:0] port_idx_t;

  // Per-output arbitration state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/switch_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection over 8 candidates.
// The scan starts at ptr_i and wraps; the first set candidate wins.
module rr_picker
  import switch_pkg::*;
(
  input  logic [7:0] cand_i,
  input  port_idx_t  ptr_i,
  output logic       valid_o,
  output port_idx_t  winner_o
);

  port_idx_t idx;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = ptr_i;
    idx      = ptr_i;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_i + port_idx_t'(k);
      if (cand_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// switch_arbiter: per-output round-robin grant generator for switch_fabric.
// Each output owns an IDLE/BUSY state machine that holds its grant for a
// whole packet. Optional watchdog forced release: define SWITCH_ARB_TIMEOUT_EN.
//
// Handshake: a beat transfers in any cycle where req[i] and grant[i] are both
// high; the packet ends on a beat with last[i], or when req[i] drops (abort).
module switch_arbiter #(
  parameter int N_PORTS        = 8,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PORTS-1:0]  req,
  input  logic [ADDR_W-1:0]   addr [N_PORTS],
  input  logic [N_PORTS-1:0]  last,
  output logic [N_PORTS-1:0]  grant,
  output logic [N_PORTS-1:0]  out_busy,
  output logic [N_PORTS-1:0]  addr_err,
  output logic [N_PORTS-1:0]  timeout_err
);
  import switch_pkg::*;

  arb_state_e state_q  [8];
  arb_state_e state_d  [8];
  port_idx_t  owner_q  [8];
  port_idx_t  owner_d  [8];
  port_idx_t  rr_ptr_q [8];
  port_idx_t  rr_ptr_d [8];
  logic [7:0] grant_q, grant_d;
  logic [7:0] busy_q, busy_d;
  logic [7:0] addr_err_q, addr_err_d;
  logic [7:0] timeout_q, timeout_d;

  logic [7:0] cand       [8];
  logic       pick_valid [8];
  port_idx_t  pick_idx   [8];
  logic       rel;

`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
`endif

  // Build per-output candidate vectors; current owners are excluded.
  always_comb begin
    for (int o = 0; o < 8; o++) begin
      cand[o] = '0;
      for (int i = 0; i < 8; i++) begin
        cand[o][i] = req[i] & ~addr[i][3] & (addr[i][2:0] == port_idx_t'(o))
                     & ~grant_q[i];
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_pick
    rr_picker u_pick (
      .cand_i   (cand[g]),
      .ptr_i    (rr_ptr_q[g]),
      .valid_o  (pick_valid[g]),
      .winner_o (pick_idx[g])
    );
  end

  // Next-state logic for every output state machine and the registered flags.
  always_comb begin
    grant_d    = '0;
    busy_d     = '0;
    timeout_d  = '0;
    addr_err_d = req & {addr[7][3], addr[6][3], addr[5][3], addr[4][3],
                        addr[3][3], addr[2][3], addr[1][3], addr[0][3]};
    rel        = 1'b0;
    for (int o = 0; o < 8; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
`ifdef SWITCH_ARB_TIMEOUT_EN
      cnt_d[o]    = (state_q[o] == BUSY) ? cnt_q[o] + CNT_W'(1) : '0;
`endif
      rel = 1'b0;
      case (state_q[o])
        IDLE: begin
          if (pick_valid[o]) begin
            state_d[o] = BUSY;
            owner_d[o] = pick_idx[o];
          end
        end
        BUSY: begin
          rel = ~req[owner_q[o]] | last[owner_q[o]];
`ifdef SWITCH_ARB_TIMEOUT_EN
          if (cnt_q[o] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d[o] = ~rel;
            rel          = 1'b1;
          end
`endif
          if (rel) begin
            state_d[o]  = IDLE;
            rr_ptr_d[o] = owner_q[o] + 3'd1;
          end
        end
        default: state_d[o] = IDLE;
      endcase
      if (state_d[o] == BUSY) begin
        grant_d[owner_d[o]] = 1'b1;
        busy_d[o]           = 1'b1;
      end
    end
  end

  // State registers; reset overrides any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 8; o++) begin
        state_q[o]  <= IDLE;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
`ifdef SWITCH_ARB_TIMEOUT_EN
        cnt_q[o]    <= '0;
`endif
      end
      grant_q    <= '0;
      busy_q     <= '0;
      addr_err_q <= '0;
      timeout_q  <= '0;
    end else begin
      for (int o = 0; o < 8; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
`ifdef SWITCH_ARB_TIMEOUT_EN
        cnt_q[o]    <= cnt_d[o];
`endif
      end
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign out_busy    = busy_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_q;

endmodule
